dic_ram_arbiter: RTL and testbench
==================================

Name: dic_ram_arbiter

Overview:
- Shares the single-port synchronous dictionary RAM of the LZW engine between three requesters: insert writer (new dictionary entries), search reader (string/code lookup) and drain reader (code emission to output buffer).
- Owns an internal init sweep that zero-fills the RAM after reset or on request, replacing ad-hoc zeroing from the microcode.
- Sits between the microprogrammed controller's datapath and the RAM macro.

Parameters:
- ADDR_W, 8, dictionary address width; depth = 2**ADDR_W.
- DATA_W, 16, dictionary entry width.
- STARVE_LIM, 4, cycles the drain requester may wait before forced grant.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse: begin zero-fill sweep.
- init_busy  out  1  high while sweep runs.
- wr_req / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  insert write request.
- wr_gnt  out  1  one-cycle grant, write performed this cycle.
- sr_req / sr_addr  in  1 / ADDR_W  search read request.
- sr_gnt  out  1  one-cycle grant.
- sr_lock  in  1  hold grant for search bursts (optional feature only).
- dr_req / dr_addr  in  1 / ADDR_W  drain read request.
- dr_gnt  out  1  one-cycle grant.
- rd_data  out  DATA_W  registered RAM read data.
- sr_rvalid / dr_rvalid  out  1  read data valid for respective requester.
- ram_en / ram_we / ram_addr / ram_wdata  out  1 / 1 / ADDR_W / DATA_W  RAM drive.
- ram_rdata  in  DATA_W  RAM output (one-cycle read latency).

Behaviour:
- Reset (reset=0): all grants, rvalids, ram_en, ram_we = 0; ram_addr, ram_wdata, rd_data = 0; starvation counter = 0; sweep address = 0; state = SWEEP, init_busy = 1.
- States: SWEEP, SERVE.
- SWEEP: every cycle ram_en=1, ram_we=1, ram_wdata=0, ram_addr=sweep address; address increments. After address 2**ADDR_W-1 is written, the next state is SERVE and init_busy falls. The sweep takes exactly 2**ADDR_W cycles. No grants are issued during SWEEP. init_start during SWEEP is ignored.
- SERVE, init_start=1: the sweep address clears and the next state is SWEEP. Any request pending in that cycle is not granted.
- Requests are level; requester holds req/addr/data stable until it sees its gnt.
- Grants are combinational from registered state and current requests. The RAM is driven in the same cycle as the grant, with at most one grant per cycle.
- Priority: forced drain (starve count = STARVE_LIM) > write > search > drain.
- Starve counter:
  - Increments each cycle dr_req=1 and dr_gnt=0, saturating at STARVE_LIM.
  - Clears on dr_gnt or dr_req=0.
- Read latency: a grant in cycle N gives rd_data and the matching rvalid in cycle N+1 for exactly one cycle. Back-to-back grants give back-to-back valid data.
- Write/read same address in consecutive cycles: read returns the new data (RAM write-first is not relied on; ordering is by grant sequence only).
- reset mid-operation: immediate return to reset values. Outstanding read data is discarded, with no rvalid.

Optional Feature:
- Macro DIC_ARB_LOCK_EN.
- Defined: if search held the grant last cycle and sr_lock=1 and sr_req=1, search is granted again, overriding write and normal drain. A forced drain still wins. Lock ends when sr_lock=0 or sr_req=0.
- Undefined: sr_lock port exists but is ignored; pure priority as above.

Decomposition:
- Shared package lzw_ctrl_pkg holds:
  - Requester id enum (REQ_NONE, REQ_WR, REQ_SR, REQ_DR, REQ_INIT).
  - Default ADDR_W/DATA_W constants used by the controller and datapath.
- Sub-module dic_init_sweeper contains the sweep address counter, init_busy, and done flag. The arbiter FSM consumes its done.

Test Plan:
- Release reset -> init_busy=1 for 256 cycles, ram_we=1 with addresses 0..255 and ram_wdata=0; no gnt asserted; init_busy=0 at cycle 256.
- After sweep, wr_req=1 addr 0x12 data 0xBEEF together with sr_req=1 addr 0x12 -> wr_gnt in cycle N; sr_gnt in N+1; sr_rvalid in N+2 with rd_data=0xBEEF.
- Continuous wr_req and dr_req=1 addr 0x05 -> dr_gnt not before the 5th cycle of waiting (STARVE_LIM=4); dr_rvalid one cycle after dr_gnt.
- init_start pulse in SERVE with pending sr_req -> no sr_gnt; init_busy=1 for 256 cycles; then sr_gnt issued.
- reset=0 asserted the cycle after sr_gnt -> sr_rvalid stays 0 and all outputs are at reset values immediately (asynchronous).
- With DIC_ARB_LOCK_EN: sr_req+sr_lock held 3 cycles against wr_req -> 3 consecutive sr_gnt, then wr_gnt. Without the macro, wr_gnt comes first.

Source files
------------

// File: rtl/lzw_ctrl_pkg.sv
// lzw_ctrl_pkg: types and default widths shared by the LZW controller, datapath and dictionary arbiter.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents:
//   LZW_ADDR_W / LZW_DATA_W / LZW_STARVE_LIM : default dictionary geometry and drain starvation limit
//   req_id_e                                 : owner of the dictionary RAM port in a given cycle
//   arb_state_e                              : arbiter top-level state
//   req_writes / req_reads                   : classify an owner as a RAM write or a RAM read
package lzw_ctrl_pkg;

  localparam int LZW_ADDR_W     = 8;
  localparam int LZW_DATA_W     = 16;
  localparam int LZW_STARVE_LIM = 4;

  // Owner of the single RAM port for one cycle. REQ_INIT is the zero-fill sweep.
  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_WR   = 3'd1,
    REQ_SR   = 3'd2,
    REQ_DR   = 3'd3,
    REQ_INIT = 3'd4
  } req_id_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_e;

  function automatic logic req_writes(input req_id_e id);
    return (id == REQ_WR) || (id == REQ_INIT);
  endfunction

  function automatic logic req_reads(input req_id_e id);
    return (id == REQ_SR) || (id == REQ_DR);
  endfunction

endpackage

// File: rtl/dic_init_sweeper.sv
// dic_init_sweeper: address counter and busy flag for the dictionary zero-fill sweep.
// Latency: a sweep lasts exactly 2**ADDR_W cycles; done_o is high during the last one.
// Backpressure: none; the sweep owns the RAM port unconditionally while busy.
//
// Ports:
//   clk_i, reset_ni : clock and asynchronous active-low reset (reset starts a sweep at address 0)
//   restart_i       : begin a new sweep from address 0 next cycle
//   addr_o          : address written this cycle while busy
//   busy_o          : sweep in progress
//   done_o          : this cycle writes the final address
module dic_init_sweeper
  import lzw_ctrl_pkg::*;
#(
  parameter int ADDR_W = LZW_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  always_comb begin
    addr_d = addr_q;
    busy_d = busy_q;
    if (restart_i) begin
      addr_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Natural wrap leaves the address at 0 once the sweep completes.
      addr_d = addr_q + ADDR_ONE;
      if (addr_q == ADDR_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr_q <= '0;
      busy_q <= 1'b1;
    end else begin
      addr_q <= addr_d;
      busy_q <= busy_d;
    end
  end

  assign addr_o = addr_q;
  assign busy_o = busy_q;
  assign done_o = busy_q && (addr_q == ADDR_LAST);

endmodule

// File: rtl/dic_ram_arbiter.sv
// dic_ram_arbiter: shares the single-port LZW dictionary RAM between insert writer, search reader,
//   drain reader and an internal zero-fill sweep.
// Latency: grant and RAM drive are combinational in the request cycle; read data/rvalid one cycle later.
// Backpressure: level requests held until the one-cycle grant; drain is forced after STARVE_LIM waits.
//
// Optional feature: define DIC_ARB_LOCK_EN to let a search burst keep the port while sr_lock_i is high.
//
// Ports:
//   clk_i, reset_ni                       : clock, asynchronous active-low reset
//   init_start_i / init_busy_o            : start zero-fill sweep (honoured only while serving) / sweep running
//   wr_req_i, wr_addr_i, wr_data_i, wr_gnt_o : insert write request and grant
//   sr_req_i, sr_addr_i, sr_gnt_o, sr_lock_i : search read request, grant and burst lock
//   dr_req_i, dr_addr_i, dr_gnt_o         : drain read request and grant
//   rd_data_o, sr_rvalid_o, dr_rvalid_o   : read data returned the cycle after a read grant
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i : RAM macro interface
module dic_ram_arbiter
  import lzw_ctrl_pkg::*;
#(
  parameter int ADDR_W     = LZW_ADDR_W,
  parameter int DATA_W     = LZW_DATA_W,
  parameter int STARVE_LIM = LZW_STARVE_LIM
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              init_start_i,
  output logic              init_busy_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              sr_req_i,
  input  logic [ADDR_W-1:0] sr_addr_i,
  output logic              sr_gnt_o,
  input  logic              sr_lock_i,
  input  logic              dr_req_i,
  input  logic [ADDR_W-1:0] dr_addr_i,
  output logic              dr_gnt_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              sr_rvalid_o,
  output logic              dr_rvalid_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int               SW         = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [SW-1:0]    STARVE_ONE = SW'(1);

  arb_state_e        state_q, state_d;
  req_id_e           winner;
  logic [SW-1:0]     starve_q, starve_d;
  logic              sr_rvalid_q, dr_rvalid_q;
  logic              sweep_restart;
  logic              sweep_busy;
  logic              sweep_done;
  logic [ADDR_W-1:0] sweep_addr;
  logic              drain_forced;

  dic_init_sweeper #(
    .ADDR_W (ADDR_W)
  ) u_sweeper (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .restart_i (sweep_restart),
    .addr_o    (sweep_addr),
    .busy_o    (sweep_busy),
    .done_o    (sweep_done)
  );

  assign drain_forced = dr_req_i && (starve_q == STARVE_MAX);

`ifdef DIC_ARB_LOCK_EN
  // Search won the port in the previous cycle; basis of the burst lock.
  logic sr_hold_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sr_hold_q <= 1'b0;
    end else begin
      sr_hold_q <= (winner == REQ_SR);
    end
  end
`else
  logic unused_sr_lock;
  assign unused_sr_lock = sr_lock_i;
`endif

  // Next state and port owner. A restart cycle grants nobody so the requester
  // keeps its request level and is served after the sweep.
  always_comb begin
    state_d       = state_q;
    winner        = REQ_NONE;
    sweep_restart = 1'b0;
    unique case (state_q)
      ST_SWEEP: begin
        winner = REQ_INIT;
        if (sweep_done) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (init_start_i) begin
          state_d       = ST_SWEEP;
          sweep_restart = 1'b1;
        end else if (drain_forced) begin
          winner = REQ_DR;
`ifdef DIC_ARB_LOCK_EN
        end else if (sr_hold_q && sr_lock_i && sr_req_i) begin
          winner = REQ_SR;
`endif
        end else if (wr_req_i) begin
          winner = REQ_WR;
        end else if (sr_req_i) begin
          winner = REQ_SR;
        end else if (dr_req_i) begin
          winner = REQ_DR;
        end
      end
      default: begin
        state_d = ST_SWEEP;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_SWEEP;
    end else begin
      state_q <= state_d;
    end
  end

  assign wr_gnt_o    = (winner == REQ_WR);
  assign sr_gnt_o    = (winner == REQ_SR);
  assign dr_gnt_o    = (winner == REQ_DR);
  assign init_busy_o = sweep_busy;

  // RAM drive follows the owner in the same cycle. The sweep owns the port from
  // reset, so its enables are qualified with reset_ni to keep the RAM idle while
  // reset is held.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    unique case (winner)
      REQ_INIT: begin
        ram_en_o   = reset_ni;
        ram_we_o   = reset_ni;
        ram_addr_o = sweep_addr;
      end
      REQ_WR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = req_writes(winner);
        ram_addr_o  = wr_addr_i;
        ram_wdata_o = wr_data_i;
      end
      REQ_SR: begin
        ram_en_o   = req_reads(winner);
        ram_addr_o = sr_addr_i;
      end
      REQ_DR: begin
        ram_en_o   = req_reads(winner);
        ram_addr_o = dr_addr_i;
      end
      default: begin
        ram_en_o = 1'b0;
      end
    endcase
  end

  // Drain wait counter: counts refused drain cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (dr_req_i && !dr_gnt_o) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : (starve_q + STARVE_ONE);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      starve_q    <= '0;
      sr_rvalid_q <= 1'b0;
      dr_rvalid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      sr_rvalid_q <= sr_gnt_o;
      dr_rvalid_q <= dr_gnt_o;
    end
  end

  // The RAM output register already provides the one-cycle read latency; data
  // is presented only alongside a valid so idle cycles read as zero.
  assign sr_rvalid_o = sr_rvalid_q;
  assign dr_rvalid_o = dr_rvalid_q;
  assign rd_data_o   = (sr_rvalid_q || dr_rvalid_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_dic_ram_arbiter.sv
// tb_dic_ram_arbiter: self-checking bench for dic_ram_arbiter with a behavioural RAM and reference model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req/addr/data until they observe their grant.
module tb_dic_ram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int LIM   = 4;

  localparam int W_NONE = 0;
  localparam int W_WR   = 1;
  localparam int W_SR   = 2;
  localparam int W_DR   = 3;
  localparam int W_SWP  = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          init_start = 1'b0;
  logic          wr_req     = 1'b0;
  logic [AW-1:0] wr_addr    = '0;
  logic [DW-1:0] wr_data    = '0;
  logic          sr_req     = 1'b0;
  logic [AW-1:0] sr_addr    = '0;
  logic          sr_lock    = 1'b0;
  logic          dr_req     = 1'b0;
  logic [AW-1:0] dr_addr    = '0;

  logic          init_busy, wr_gnt, sr_gnt, dr_gnt, sr_rvalid, dr_rvalid;
  logic [DW-1:0] rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];

  int checks = 0;
  int errors = 0;

  dic_ram_arbiter dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .init_start_i (init_start),
    .init_busy_o  (init_busy),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_gnt_o     (wr_gnt),
    .sr_req_i     (sr_req),
    .sr_addr_i    (sr_addr),
    .sr_gnt_o     (sr_gnt),
    .sr_lock_i    (sr_lock),
    .dr_req_i     (dr_req),
    .dr_addr_i    (dr_addr),
    .dr_gnt_o     (dr_gnt),
    .rd_data_o    (rd_data),
    .sr_rvalid_o  (sr_rvalid),
    .dr_rvalid_o  (dr_rvalid),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    wr_req = 1'b0; sr_req = 1'b0; dr_req = 1'b0; sr_lock = 1'b0; init_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_gnt, sr_gnt, dr_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got %b want 000", {wr_gnt, sr_gnt, dr_gnt});
    end
    checks++;
    if ({ram_en, ram_we} !== 2'b00) begin
      errors++; $display("FAIL reset_ram_en_we: got %b want 00", {ram_en, ram_we});
    end
    checks++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      errors++; $display("FAIL reset_ram_bus: got addr %h wdata %h want 0 0", ram_addr, ram_wdata);
    end
    checks++;
    if ({sr_rvalid, dr_rvalid} !== 2'b00 || rd_data !== '0) begin
      errors++; $display("FAIL reset_rd: got rvalid %b data %h want 00 0000", {sr_rvalid, dr_rvalid}, rd_data);
    end
    checks++;
    if (init_busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", init_busy);
    end
  endtask

  // Sweep after reset release, with a search waiting and an init_start pulse mid-sweep.
  task automatic test_sweep();
    @(posedge clk); #1;
    reset_n = 1'b1;
    sr_req  = 1'b1;
    sr_addr = 8'h40;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (init_busy !== 1'b1) begin
        errors++; $display("FAIL sweep_busy c%0d: got %b want 1", k, init_busy);
      end
      checks++;
      if ({ram_en, ram_we} !== 2'b11 || ram_addr !== AW'(k) || ram_wdata !== '0) begin
        errors++; $display("FAIL sweep_drive c%0d: got en/we %b addr %h wdata %h want 11 %h 0000",
                           k, {ram_en, ram_we}, ram_addr, ram_wdata, AW'(k));
      end
      checks++;
      if ({wr_gnt, sr_gnt, dr_gnt} !== 3'b000) begin
        errors++; $display("FAIL sweep_gnt c%0d: got %b want 000", k, {wr_gnt, sr_gnt, dr_gnt});
      end
      shadow[k] = '0;
      @(posedge clk); #1;
      init_start = (k == 99);
    end
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b0) begin
      errors++; $display("FAIL sweep_end_busy: got %b want 0", init_busy);
    end
    checks++;
    if (sr_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h40) begin
      errors++; $display("FAIL sweep_first_gnt: got gnt %b en %b we %b addr %h want 1 1 0 40",
                         sr_gnt, ram_en, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    sr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (sr_rvalid !== 1'b1 || rd_data !== '0) begin
      errors++; $display("FAIL sweep_zero_read: got rvalid %b data %h want 1 0000", sr_rvalid, rd_data);
    end
  endtask

  // Write and search of the same address requested together.
  task automatic test_wr_sr_same_addr();
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 8'h12; wr_data = 16'hBEEF;
    sr_req = 1'b1; sr_addr = 8'h12;
    @(negedge clk);
    checks++;
    if ({wr_gnt, sr_gnt, dr_gnt} !== 3'b100) begin
      errors++; $display("FAIL wrsr_n_gnt: got %b want 100", {wr_gnt, sr_gnt, dr_gnt});
    end
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h12 || ram_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL wrsr_n_ram: got we %b addr %h wdata %h want 1 12 beef", ram_we, ram_addr, ram_wdata);
    end
    shadow[8'h12] = 16'hBEEF;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_gnt, sr_gnt, dr_gnt} !== 3'b010 || ram_we !== 1'b0 || ram_addr !== 8'h12) begin
      errors++; $display("FAIL wrsr_n1_gnt: got gnt %b we %b addr %h want 010 0 12",
                         {wr_gnt, sr_gnt, dr_gnt}, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    sr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (sr_rvalid !== 1'b1 || dr_rvalid !== 1'b0 || rd_data !== 16'hBEEF) begin
      errors++; $display("FAIL wrsr_n2_read: got srv %b drv %b data %h want 1 0 beef", sr_rvalid, dr_rvalid, rd_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sr_rvalid !== 1'b0) begin
      errors++; $display("FAIL wrsr_n3_single: got rvalid %b want 0", sr_rvalid);
    end
  endtask

  // Continuous writes against a drain: drain is forced on its fifth waiting cycle.
  task automatic test_starve();
    logic [DW-1:0] exp_rd;
    exp_rd = '0;
    @(posedge clk); #1;
    dr_req = 1'b1; dr_addr = 8'h05;
    wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 15)); wr_data = DW'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (dr_gnt !== (c == 5) || wr_gnt !== (c != 5) || sr_gnt !== 1'b0) begin
        errors++; $display("FAIL starve_gnt c%0d: got wr %b dr %b want wr %b dr %b",
                           c, wr_gnt, dr_gnt, (c != 5), (c == 5));
      end
      if (c == 5) begin
        exp_rd = shadow[8'h05];
        checks++;
        if (ram_addr !== 8'h05 || ram_we !== 1'b0) begin
          errors++; $display("FAIL starve_ram: got addr %h we %b want 05 0", ram_addr, ram_we);
        end
      end
      checks++;
      if (dr_rvalid !== (c == 6) || (c == 6 && rd_data !== exp_rd)) begin
        errors++; $display("FAIL starve_rvalid c%0d: got %b data %h want %b data %h",
                           c, dr_rvalid, rd_data, (c == 6), exp_rd);
      end
      if (c != 5) shadow[wr_addr] = wr_data;
      @(posedge clk); #1;
      dr_req = (c < 5);
      if (c != 5) begin
        wr_addr = AW'($urandom_range(0, 15));
        wr_data = DW'($urandom);
      end
    end
    wr_req = 1'b0;
    dr_req = 1'b0;
  endtask

  // init_start while serving a pending search: no grant, full sweep, then the search.
  task automatic test_init_restart();
    @(posedge clk); #1;
    sr_req = 1'b1; sr_addr = 8'h12; init_start = 1'b1;
    @(negedge clk);
    checks++;
    if (sr_gnt !== 1'b0 || ram_en !== 1'b0) begin
      errors++; $display("FAIL restart_nogrant: got gnt %b en %b want 0 0", sr_gnt, ram_en);
    end
    @(posedge clk); #1;
    init_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (init_busy !== 1'b1 || sr_gnt !== 1'b0 || ram_addr !== AW'(k) || ram_we !== 1'b1) begin
        errors++; $display("FAIL restart_sweep c%0d: got busy %b gnt %b addr %h we %b want 1 0 %h 1",
                           k, init_busy, sr_gnt, ram_addr, ram_we, AW'(k));
      end
      shadow[k] = '0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b0 || sr_gnt !== 1'b1) begin
      errors++; $display("FAIL restart_after: got busy %b gnt %b want 0 1", init_busy, sr_gnt);
    end
    @(posedge clk); #1;
    sr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (sr_rvalid !== 1'b1 || rd_data !== '0) begin
      errors++; $display("FAIL restart_cleared: got rvalid %b data %h want 1 0000", sr_rvalid, rd_data);
    end
  endtask

  // Locked search burst against a competing write.
  task automatic test_lock();
    logic [3:0] exp_sr, exp_wr;
`ifdef DIC_ARB_LOCK_EN
    exp_sr = 4'b0111; exp_wr = 4'b1000;
`else
    exp_sr = 4'b0101; exp_wr = 4'b0010;
`endif
    @(posedge clk); #1;
    sr_req = 1'b1; sr_lock = 1'b1; sr_addr = AW'($urandom_range(0, 255)); wr_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (sr_gnt !== exp_sr[c] || wr_gnt !== exp_wr[c] || dr_gnt !== 1'b0) begin
        errors++; $display("FAIL lock_gnt c%0d: got sr %b wr %b want sr %b wr %b",
                           c, sr_gnt, wr_gnt, exp_sr[c], exp_wr[c]);
      end
      if (exp_wr[c]) shadow[wr_addr] = wr_data;
      @(posedge clk); #1;
      if (exp_wr[c]) wr_req = 1'b0;
      if (c == 0) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 255)); wr_data = DW'($urandom);
      end
      sr_req  = (c + 1 < 3);
      sr_lock = (c + 1 < 3);
      if (exp_sr[c]) sr_addr = AW'($urandom_range(0, 255));
    end
    wr_req = 1'b0; sr_req = 1'b0; sr_lock = 1'b0;
  endtask

  // Random traffic from reset against a rule-level model of ownership, drain waiting and RAM contents.
  task automatic test_random();
    int            win, m_sw, m_starve, m_rd;
    logic          m_busy, m_last_sr, lock_hit, exp_en, exp_we;
    logic [DW-1:0] m_rd_val, exp_wdata;
    logic [AW-1:0] exp_addr;
    reset_n = 1'b0;
    wr_req = 1'b0; sr_req = 1'b0; dr_req = 1'b0; sr_lock = 1'b0; init_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_busy = 1'b1; m_sw = 0; m_starve = 0; m_rd = 0; m_last_sr = 1'b0; m_rd_val = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      lock_hit = 1'b0;
`ifdef DIC_ARB_LOCK_EN
      lock_hit = m_last_sr && sr_lock && sr_req;
`endif
      if (m_busy)                          win = W_SWP;
      else if (init_start)                 win = W_NONE;
      else if (dr_req && m_starve == LIM)  win = W_DR;
      else if (lock_hit)                   win = W_SR;
      else if (wr_req)                     win = W_WR;
      else if (sr_req)                     win = W_SR;
      else if (dr_req)                     win = W_DR;
      else                                 win = W_NONE;
      exp_en    = (win != W_NONE);
      exp_we    = (win == W_WR) || (win == W_SWP);
      exp_wdata = (win == W_WR) ? wr_data : '0;
      case (win)
        W_SWP:   exp_addr = AW'(m_sw);
        W_WR:    exp_addr = wr_addr;
        W_SR:    exp_addr = sr_addr;
        W_DR:    exp_addr = dr_addr;
        default: exp_addr = '0;
      endcase
      checks++;
      if ({wr_gnt, sr_gnt, dr_gnt} !== {win == W_WR, win == W_SR, win == W_DR}) begin
        errors++; $display("FAIL rand_gnt c%0d: got %b want %b", cyc,
                           {wr_gnt, sr_gnt, dr_gnt}, {win == W_WR, win == W_SR, win == W_DR});
      end
      checks++;
      if ({ram_en, ram_we} !== {exp_en, exp_we}) begin
        errors++; $display("FAIL rand_en_we c%0d: got %b want %b", cyc, {ram_en, ram_we}, {exp_en, exp_we});
      end
      if (exp_en) begin
        checks++;
        if (ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
          errors++; $display("FAIL rand_ram c%0d: got addr %h wdata %h want %h %h",
                             cyc, ram_addr, ram_wdata, exp_addr, exp_wdata);
        end
      end
      checks++;
      if (init_busy !== m_busy) begin
        errors++; $display("FAIL rand_busy c%0d: got %b want %b", cyc, init_busy, m_busy);
      end
      checks++;
      if ({sr_rvalid, dr_rvalid} !== {m_rd == 1, m_rd == 2}) begin
        errors++; $display("FAIL rand_rvalid c%0d: got %b want %b", cyc, {sr_rvalid, dr_rvalid}, {m_rd == 1, m_rd == 2});
      end
      if (m_rd != 0) begin
        checks++;
        if (rd_data !== m_rd_val) begin
          errors++; $display("FAIL rand_rdata c%0d: got %h want %h", cyc, rd_data, m_rd_val);
        end
      end
      m_rd = (win == W_SR) ? 1 : (win == W_DR) ? 2 : 0;
      if (win == W_SR) m_rd_val = shadow[sr_addr];
      if (win == W_DR) m_rd_val = shadow[dr_addr];
      if (win == W_WR) shadow[wr_addr] = wr_data;
      if (m_busy) begin
        shadow[m_sw] = '0;
        m_sw++;
        if (m_sw == DEPTH) begin
          m_busy = 1'b0;
          m_sw   = 0;
        end
      end else if (init_start) begin
        m_busy = 1'b1;
        m_sw   = 0;
      end
      if (dr_req && win != W_DR) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else                       m_starve = 0;
      m_last_sr = (win == W_SR);
      @(posedge clk); #1;
      init_start = ($urandom_range(0, 299) == 0);
      if (!wr_req || win == W_WR) begin
        wr_req = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 15)); wr_data = DW'($urandom);
      end
      if (!sr_req || win == W_SR) begin
        sr_req = 1'($urandom_range(0, 1)); sr_addr = AW'($urandom_range(0, 15));
      end
      if (!dr_req || win == W_DR) begin
        dr_req = 1'($urandom_range(0, 1)); dr_addr = AW'($urandom_range(0, 15));
      end
      sr_lock = 1'($urandom_range(0, 1));
    end
    wr_req = 1'b0; sr_req = 1'b0; dr_req = 1'b0; sr_lock = 1'b0; init_start = 1'b0;
  endtask

  // Reset asserted right after a search grant: no rvalid, outputs back to reset values at once.
  task automatic test_reset_mid();
    int waited;
    waited = 0;
    while (init_busy !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (init_busy !== 1'b0) begin
      errors++; $display("FAIL mid_settle: got busy %b want 0 within 400 cycles", init_busy);
    end
    @(posedge clk); #1;
    sr_req = 1'b1; sr_addr = 8'h03;
    @(negedge clk);
    checks++;
    if (sr_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got %b want 1", sr_gnt);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({wr_gnt, sr_gnt, dr_gnt, ram_en, ram_we} !== 5'b00000 || ram_addr !== '0 || ram_wdata !== '0) begin
      errors++; $display("FAIL mid_async: got gnt/en/we %b addr %h wdata %h want 00000 00 0000",
                         {wr_gnt, sr_gnt, dr_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
    end
    checks++;
    if (init_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b want 1", init_busy);
    end
    @(negedge clk);
    checks++;
    if ({sr_rvalid, dr_rvalid} !== 2'b00 || rd_data !== '0) begin
      errors++; $display("FAIL mid_rvalid: got %b data %h want 00 0000", {sr_rvalid, dr_rvalid}, rd_data);
    end
    sr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_wr_sr_same_addr();
    test_starve();
    test_init_restart();
    test_lock();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
